// File: rtl/board_move_engine.sv
// Board RAM front end for the Othello core: wall-ring init sweep, checked move commit,
// piece counters and end-of-game detection.
module board_move_engine #(
  parameter int BOARD_N = 8,
  parameter int ADDR_W  = 7,
  parameter int RC_W    = 3,
  parameter int CNT_W   = 7,
  parameter int RD_LAT  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              init_req,
  output logic              init_busy,
  input  logic              mv_req,
  input  logic [RC_W-1:0]   mv_row,
  input  logic [RC_W-1:0]   mv_col,
  input  logic              mv_player,
  output logic              mv_ack,
  output logic              mv_nack,
  input  logic              pass_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_wdata,
  output logic              mem_wren,
  input  logic [1:0]        mem_rdata,
  output logic [ADDR_W-1:0] s_addr_out,
  output logic [CNT_W-1:0]  black_cnt,
  output logic [CNT_W-1:0]  white_cnt,
  output logic              game_end
);
  localparam int EDGE = BOARD_N + 2;
  localparam int HALF = BOARD_N / 2;
  localparam int PW   = $clog2(EDGE);
  localparam int LW   = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W:0] FULL = (CNT_W+1)'(BOARD_N * BOARD_N);

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_RD, S_WAIT, S_WR, S_RESP, S_END} state_t;
  state_t state;

  logic [PW-1:0]     sweep_r, sweep_c, nxt_r, nxt_c;
  logic [LW-1:0]     wait_cnt;
  logic [ADDR_W-1:0] cur_addr, req_addr;
  logic              cur_player, pass_cnt, init_done;
  logic              req_ok, sample_now, start_init;
  logic [CNT_W:0]    pieces;

  // Initial cell code at ring coordinates (r, c), wall ring included.
  function automatic logic [1:0] cell_code(input logic [PW-1:0] r, input logic [PW-1:0] c);
    int ri, ci;
    ri = int'(r);
    ci = int'(c);
    if (ri == 0 || ci == 0 || ri == EDGE - 1 || ci == EDGE - 1) return 2'b11;
    if ((ri == HALF && ci == HALF) || (ri == HALF + 1 && ci == HALF + 1)) return 2'b10;
    if ((ri == HALF && ci == HALF + 1) || (ri == HALF + 1 && ci == HALF)) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    nxt_r = sweep_r;
    nxt_c = sweep_c + PW'(1);
    if (sweep_c == PW'(EDGE - 1)) begin
      nxt_c = '0;
      nxt_r = sweep_r + PW'(1);
    end
  end

  assign req_addr   = ADDR_W'((int'(mv_row) + 1) * EDGE + int'(mv_col) + 1);
  assign req_ok     = (int'(mv_row) < BOARD_N) && (int'(mv_col) < BOARD_N) && init_done;
  // RD already counts as the first latency cycle; WAIT covers the rest.
  assign sample_now = (state == S_RD) ? (RD_LAT == 1) : (wait_cnt == '0);
  assign start_init = init_req && (state == S_IDLE || state == S_END);
  assign pieces     = {1'b0, black_cnt} + {1'b0, white_cnt};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= S_IDLE;
      init_busy  <= 1'b0;
      mv_ack     <= 1'b0;
      mv_nack    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wren   <= 1'b0;
      s_addr_out <= '0;
      black_cnt  <= '0;
      white_cnt  <= '0;
      game_end   <= 1'b0;
      init_done  <= 1'b0;
      pass_cnt   <= 1'b0;
      sweep_r    <= '0;
      sweep_c    <= '0;
      wait_cnt   <= '0;
      cur_addr   <= '0;
      cur_player <= 1'b0;
    end else begin
      mv_ack  <= 1'b0;
      mv_nack <= 1'b0;
      if (start_init) begin
        state     <= S_INIT;
        init_busy <= 1'b1;
        game_end  <= 1'b0;
        mem_addr  <= '0;
        mem_wren  <= 1'b1;
        mem_wdata <= cell_code(PW'(0), PW'(0));
        sweep_r   <= '0;
        sweep_c   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (mv_req) begin
              cur_addr   <= req_addr;
              cur_player <= mv_player;
              if (req_ok) begin
                mem_addr <= req_addr;
                state    <= S_RD;
              end else begin
                mv_nack <= 1'b1;
                state   <= S_RESP;
              end
            end else if (pass_in) begin
              if (pass_cnt) begin
                game_end <= 1'b1;
                state    <= S_END;
              end else begin
                pass_cnt <= 1'b1;
              end
            end
          end
          S_INIT: begin
            if (mem_addr == ADDR_W'(EDGE * EDGE - 1)) begin
              mem_wren  <= 1'b0;
              init_busy <= 1'b0;
              black_cnt <= CNT_W'(2);
              white_cnt <= CNT_W'(2);
              game_end  <= 1'b0;
              pass_cnt  <= 1'b0;
              init_done <= 1'b1;
              state     <= S_IDLE;
            end else begin
              mem_addr  <= mem_addr + ADDR_W'(1);
              sweep_r   <= nxt_r;
              sweep_c   <= nxt_c;
              mem_wdata <= cell_code(nxt_r, nxt_c);
            end
          end
          S_RD, S_WAIT: begin
            if (sample_now) begin
              if (mem_rdata == 2'b00) begin
                mem_wren  <= 1'b1;
                mem_wdata <= cur_player ? 2'b10 : 2'b01;
                state     <= S_WR;
              end else begin
                mv_nack <= 1'b1;
                state   <= S_RESP;
              end
            end else if (state == S_RD) begin
              wait_cnt <= LW'(RD_LAT - 2);
              state    <= S_WAIT;
            end else begin
              wait_cnt <= wait_cnt - LW'(1);
            end
          end
          S_WR: begin
            mem_wren   <= 1'b0;
            mv_ack     <= 1'b1;
            s_addr_out <= cur_addr;
            pass_cnt   <= 1'b0;
            if (cur_player) white_cnt <= white_cnt + CNT_W'(1);
            else            black_cnt <= black_cnt + CNT_W'(1);
            if ((pieces + (CNT_W+1)'(1)) == FULL) game_end <= 1'b1;
            state <= S_RESP;
          end
          S_RESP: state <= game_end ? S_END : S_IDLE;
          S_END: begin
            if (mv_req) begin
              mv_nack <= 1'b1;
              state   <= S_RESP;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule
